// File: rtl/cpu_core_bus.sv
// cpu_core_bus: multicycle CPU with 16-bit instructions, a configurable datapath and a single
// req/ack memory port shared by instruction fetch and data access. Includes a resumable HALT
// and a combinational debug read of the register file.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   mem_req    memory request, held high until the accepting cycle
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   access address (ADDR_WIDTH)
//   mem_wdata  write data (REG_WIDTH)
//   mem_ack    access completes on a rising edge where mem_req && mem_ack
//   mem_rdata  read data, sampled in the accepting cycle
//   resume     one-cycle pulse that leaves HALT
//   halted     core is in HALT
//   pc         current program counter
//   dbg_sel    debug register index
//   dbg_val    combinational value of register[dbg_sel]
module cpu_core_bus #(
  parameter int unsigned           REG_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic                  resume,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [2:0]            dbg_sel,
  output logic [REG_WIDTH-1:0]  dbg_val
);

  localparam logic [3:0] OpHalt = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpAddi = 4'd5;
  localparam logic [3:0] OpLw   = 4'd6;
  localparam logic [3:0] OpSw   = 4'd7;
  localparam logic [3:0] OpBeq  = 4'd8;
  localparam logic [3:0] OpJ    = 4'd9;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_e;

  state_e                state_q;
  logic [15:0]           ir_q;
  logic [REG_WIDTH-1:0]  rf_q [8];
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [REG_WIDTH-1:0]  mem_wdata_q;
  logic                  halted_q;

  logic [3:0]            op;
  logic [2:0]            rs_idx, rt_idx, rd_idx;
  logic [5:0]            imm6;
  logic [REG_WIDTH-1:0]  rs_val, rt_val, rd_val, imm_ext, alu_res;
  logic [ADDR_WIDTH-1:0] imm_a, jimm_a, pc_inc, ea_addr, next_pc;
  logic                  alu_wr;

  // Decode and operand read; everything here depends only on the latched instruction.
  always_comb begin
    op      = ir_q[15:12];
    imm6    = ir_q[11:6];
    rs_idx  = ir_q[8:6];
    rt_idx  = ir_q[5:3];
    rd_idx  = ir_q[2:0];
    rs_val  = rf_q[rs_idx];
    rt_val  = rf_q[rt_idx];
    rd_val  = rf_q[rd_idx];
    imm_ext = REG_WIDTH'($signed(imm6));
    imm_a   = ADDR_WIDTH'($signed(imm6));
    jimm_a  = ADDR_WIDTH'($signed(ir_q[11:0]));
    pc_inc  = pc_q + ADDR_WIDTH'(1);
    // Only the low address bits of sext(imm6)+rt are ever used, so add at address width.
    ea_addr = imm_a + rt_val[ADDR_WIDTH-1:0];

    alu_wr  = 1'b0;
    alu_res = '0;
    case (op)
      OpAdd:   begin alu_res = rs_val + rt_val;  alu_wr = 1'b1; end
      OpSub:   begin alu_res = rs_val - rt_val;  alu_wr = 1'b1; end
      OpAnd:   begin alu_res = rs_val & rt_val;  alu_wr = 1'b1; end
      OpOr:    begin alu_res = rs_val | rt_val;  alu_wr = 1'b1; end
      OpAddi:  begin alu_res = imm_ext + rt_val; alu_wr = 1'b1; end
      default: ;
    endcase

    next_pc = pc_inc;
    if (op == OpBeq && rt_val == rd_val) begin
      next_pc = pc_inc + imm_a;
    end else if (op == OpJ) begin
      next_pc = jimm_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      pc_q        <= RESET_PC;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
        end
        StFetch: begin
          if (mem_ack) begin
            ir_q      <= mem_rdata[15:0];
            mem_req_q <= 1'b0;
            state_q   <= StExec;
          end
        end
        StExec: begin
          if (op == OpHalt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (op == OpLw || op == OpSw) begin
            state_q     <= StMem;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op == OpSw);
            mem_addr_q  <= ea_addr;
            mem_wdata_q <= rd_val;
          end else begin
            if (alu_wr) rf_q[rd_idx] <= alu_res;
            pc_q       <= next_pc;
            state_q    <= StFetch;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= next_pc;
          end
        end
        StMem: begin
          // mem_req stays high: the data access rolls straight into the next fetch.
          if (mem_ack) begin
            if (!mem_we_q) rf_q[rd_idx] <= mem_rdata;
            pc_q       <= pc_inc;
            state_q    <= StFetch;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_inc;
          end
        end
        StHalt: begin
          if (resume) begin
            halted_q   <= 1'b0;
            pc_q       <= pc_inc;
            state_q    <= StFetch;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign pc        = pc_q;
  assign dbg_val   = rf_q[dbg_sel];

endmodule

// File: tb/tb_cpu_core_bus.sv
// Bench for cpu_core_bus: directed programs plus random programs, checked against an
// instruction-level interpreter with its own memory image and access trace.
module tb_cpu_core_bus;
  localparam int unsigned    RW  = 32;
  localparam int unsigned    AW  = 16;
  localparam logic [AW-1:0]  RPC = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req, mem_we, halted;
  logic          mem_ack = 1'b0;
  logic          resume  = 1'b0;
  logic [AW-1:0] mem_addr, pc;
  logic [RW-1:0] mem_wdata, mem_rdata, dbg_val;
  logic [2:0]    dbg_sel = 3'd0;

  cpu_core_bus #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resume(resume),
    .halted(halted), .pc(pc), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // ---------------- memory responder ----------------
  logic [RW-1:0] mem [65536];
  assign mem_rdata = mem[mem_addr];

  int          wait_mode = 0;   // <0: random 0..3 wait cycles, else fixed
  bit          idle_noise = 1'b0;
  int          wait_left, cyc, waits, acc_len, len_min, len_max, first_req_cyc, halt_cyc;
  bit          busy, hold_valid;
  logic [48:0] hold;
  logic [48:0] dut_log[$];

  always @(posedge clk) begin
    if (!rst) begin
      cyc++;
      if (mem_req) begin
        acc_len++;
        if (mem_ack) begin
          dut_log.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
          if (mem_we) mem[mem_addr] = mem_wdata;
          if (acc_len < len_min) len_min = acc_len;
          if (acc_len > len_max) len_max = acc_len;
          acc_len = 0; busy = 1'b0; hold_valid = 1'b0;
        end else begin
          waits++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0; busy = 1'b0; hold_valid = 1'b0; acc_len = 0;
    end else begin
      if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (mem_req) begin
        if (hold_valid) check_eq("req_stable", {mem_we, mem_addr, mem_wdata}, hold);
        hold = {mem_we, mem_addr, mem_wdata}; hold_valid = 1'b1;
        if (!busy) begin
          busy = 1'b1;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (wait_left == 0) mem_ack = 1'b1;
        else begin mem_ack = 1'b0; wait_left--; end
      end else begin
        mem_ack = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- reference interpreter ----------------
  logic [RW-1:0] ref_mem [65536];
  logic [RW-1:0] ref_rf [8];
  logic [AW-1:0] ref_pc;
  logic [48:0]   ref_log[$];
  int            exp_cycles;

  function automatic logic [RW-1:0] sext6(input logic [5:0] v);
    return {{(RW-6){v[5]}}, v};
  endfunction

  function automatic logic [RW-1:0] sext12(input logic [11:0] v);
    return {{(RW-12){v[11]}}, v};
  endfunction

  task automatic model_run(input int max_steps, output bit done);
    logic [15:0] ins;
    logic [RW-1:0] a, b, d, off, ea_full, jt;
    logic [AW-1:0] ea;
    done = 1'b0; exp_cycles = 0; ref_log.delete();
    for (int r = 0; r < 8; r++) ref_rf[r] = '0;
    ref_pc = RPC;
    for (int s = 0; s < max_steps && !done; s++) begin
      ins = ref_mem[ref_pc][15:0];
      ref_log.push_back({1'b0, ref_pc, ref_mem[ref_pc]});
      a = ref_rf[ins[8:6]]; b = ref_rf[ins[5:3]]; d = ref_rf[ins[2:0]];
      off = sext6(ins[11:6]); ea_full = off + b; ea = ea_full[AW-1:0];
      jt = sext12(ins[11:0]);
      exp_cycles += (ins[15:12] == 4'd6 || ins[15:12] == 4'd7) ? 3 : 2;
      case (ins[15:12])
        4'd0: done = 1'b1;
        4'd1: ref_rf[ins[2:0]] = a + b;
        4'd2: ref_rf[ins[2:0]] = a - b;
        4'd3: ref_rf[ins[2:0]] = a & b;
        4'd4: ref_rf[ins[2:0]] = a | b;
        4'd5: ref_rf[ins[2:0]] = off + b;
        4'd6: begin
          ref_log.push_back({1'b0, ea, ref_mem[ea]});
          ref_rf[ins[2:0]] = ref_mem[ea];
        end
        4'd7: begin
          ref_log.push_back({1'b1, ea, d});
          ref_mem[ea] = d;
        end
        default: ;
      endcase
      if (!done) begin
        if (ins[15:12] == 4'd8 && b == d) ref_pc = ref_pc + 16'd1 + off[AW-1:0];
        else if (ins[15:12] == 4'd9)      ref_pc = jt[AW-1:0];
        else                              ref_pc = ref_pc + 16'd1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [15:0] i_r(input logic [3:0] op, input logic [2:0] rd, rs, rt);
    return {op, 3'b000, rs, rt, rd};
  endfunction

  function automatic logic [15:0] i_i(input logic [3:0] op, input logic [2:0] rd, rt,
                                      input int imm);
    logic [5:0] v;
    v = 6'(imm);
    return {op, v, rt, rd};
  endfunction

  function automatic logic [AW-1:0] log_addr(input int idx);
    logic [48:0] e;
    if (idx < 0 || idx >= dut_log.size()) return '1;
    e = dut_log[idx];
    return e[47:32];
  endfunction

  task automatic load(input int addr, input logic [RW-1:0] w);
    mem[addr] = w; ref_mem[addr] = w;
  endtask

  task automatic begin_prog();
    rst = 1'b1; resume = 1'b0;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
  endtask

  task automatic release_rst();
    @(negedge clk); @(negedge clk);
    cyc = 0; waits = 0; first_req_cyc = -1; halt_cyc = -1;
    len_min = 1000; len_max = 0; dut_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 20000) begin @(negedge clk); n++; end
  endtask

  task automatic read_reg(input int r, output logic [RW-1:0] v);
    dbg_sel = 3'(r); #1; v = dbg_val;
  endtask

  task automatic finish_prog(input string tag);
    int bad = 0; int diffs = 0;
    logic [RW-1:0] v;
    wait_halt();
    check_eq({tag, ":halted"}, halted, 1'b1);
    repeat (2) @(negedge clk);
    check_eq({tag, ":pc"}, pc, ref_pc);
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      check_eq($sformatf("%s:r%0d", tag, r), v, ref_rf[r]);
    end
    for (int i = 0; i < ref_log.size() && i < dut_log.size(); i++)
      if (dut_log[i] !== ref_log[i]) bad++;
    check_eq({tag, ":trace_len"}, dut_log.size(), ref_log.size());
    check_eq({tag, ":trace_bad"}, bad, 0);
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check_eq({tag, ":mem_diffs"}, diffs, 0);
    check_eq({tag, ":cycles"}, halt_cyc - first_req_cyc, exp_cycles + waits);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n;
    logic [RW-1:0] v;
    logic [15:0] w;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {mem_req, mem_we, halted, mem_addr, mem_wdata},
             {3'b000, 16'h0, 32'h0});
    check_eq("rst_pc", pc, RPC);
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      check_eq($sformatf("rst_r%0d", r), v, '0);
    end

    // ADDI/ADD/HALT with ack tied high
    begin_prog(); wait_mode = 0; idle_noise = 1'b0;
    load(0, {16'h0, i_i(5, 1, 0, 5)});
    load(1, {16'h0, i_i(5, 2, 0, -3)});
    load(2, {16'h0, i_r(1, 3, 1, 2)});
    load(3, 32'h0);
    model_run(100, ok);
    release_rst();
    finish_prog("alu");
    read_reg(3, v);
    check_eq("alu_r3", v, 32'd2);
    check_eq("alu_pc", pc, 16'd3);
    check_eq("alu_cycles", halt_cyc - first_req_cyc, 8);

    // SW then LW through 0x40 with three wait cycles per access
    begin_prog(); wait_mode = 3;
    load(0, {16'h0, i_i(5, 5, 0, 31)});
    load(1, {16'h0, i_i(6, 1, 5, 17)});
    load(2, {16'h0, i_i(5, 6, 5, 31)});
    load(3, {16'h0, i_i(7, 1, 6, 2)});
    load(4, {16'h0, i_i(6, 4, 6, 2)});
    load(5, 32'h0);
    load(48, 32'h1234);
    model_run(100, ok);
    release_rst();
    finish_prog("ldst");
    read_reg(4, v);
    check_eq("ldst_r4", v, 32'h1234);
    check_eq("ldst_mem40", mem[64], 32'h1234);
    check_eq("ldst_req_len", {len_min[15:0], len_max[15:0]}, {16'd4, 16'd4});

    // BEQ taken backwards, then not taken, then J to 0xFFFF
    begin_prog(); wait_mode = 0;
    load(0, {16'h0, i_i(5, 3, 0, 1)});
    for (int a = 1; a < 4; a++) load(a, 32'hA000);
    load(4, {16'h0, i_i(5, 2, 2, 1)});
    load(5, {16'h0, i_i(8, 3, 2, -2)});
    load(6, {16'h0, 4'd9, 12'hFFF});
    model_run(100, ok);
    release_rst();
    finish_prog("br");
    check_eq("beq_taken", log_addr(6), 16'd4);
    check_eq("beq_not_taken", log_addr(8), 16'd6);
    check_eq("j_target", pc, 16'hFFFF);

    // 32-bit arithmetic wrap and address truncation
    begin_prog(); wait_mode = 1;
    load(0, {16'h0, i_i(5, 1, 0, -1)});
    load(1, {16'h0, i_r(1, 2, 1, 1)});
    load(2, {16'h0, i_i(6, 4, 2, 0)});
    load(3, 32'h0);
    load(16'hFFFE, 32'hCAFE0001);
    model_run(100, ok);
    release_rst();
    finish_prog("w32");
    read_reg(2, v);
    check_eq("w32_r2", v, 32'hFFFFFFFE);
    check_eq("w32_lw_addr", log_addr(3), 16'hFFFE);

    // halt and resume
    begin_prog(); wait_mode = 3;
    load(0, 32'hA000); load(1, 32'hA000); load(2, 32'h0);
    load(3, {16'h0, i_i(5, 1, 0, 9)}); load(4, 32'h0);
    release_rst();
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    resume = 1'b1; @(negedge clk); resume = 1'b0;   // lands in FETCH
    wait_halt();
    check_eq("hr_halt_pc", {halted, pc}, {1'b1, 16'd2});
    repeat (10) @(negedge clk);
    check_eq("hr_stays", {halted, pc}, {1'b1, 16'd2});
    resume = 1'b1; @(negedge clk); resume = 1'b0;
    check_eq("hr_resume", {halted, mem_req, mem_we, mem_addr, pc}, {3'b010, 16'd3, 16'd3});
    n = 0;
    while (log_addr(dut_log.size() - 1) != 16'd4 && n < 200) begin @(negedge clk); n++; end
    resume = 1'b1; @(negedge clk); resume = 1'b0;   // edge that enters HALT
    repeat (3) @(negedge clk);
    check_eq("hr_entry_resume", {halted, mem_req, pc}, {2'b10, 16'd4});
    read_reg(1, v);
    check_eq("hr_r1", v, 32'd9);

    // reset while a store is waiting
    begin_prog(); wait_mode = 5;
    load(0, {16'h0, i_i(5, 1, 0, 5)});
    load(1, {16'h0, i_i(7, 1, 0, 31)});
    load(2, 32'h0);
    model_run(100, ok);
    release_rst();
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1 check_eq("mid_rst_out", {mem_req, halted, pc}, {2'b00, RPC});
    read_reg(1, v);
    check_eq("mid_rst_r1", v, '0);
    @(negedge clk);
    check_eq("mid_rst_nowrite", mem[31], '0);
    release_rst();
    finish_prog("mid_rst");
    check_eq("mid_rst_first_fetch", log_addr(0), RPC);

    // random programs with random wait states and stray acks while idle
    wait_mode = -1; idle_noise = 1'b1;
    for (int p = 0; p < 25; p++) begin
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        begin_prog();
        for (int a = 0; a < 24; a++) begin
          w = 16'($urandom);
          w[15:12] = 4'($urandom_range(1, 15));
          if (w[15:12] == 4'd9) w[11:0] = 12'($urandom_range(0, 27));
          load(a, {16'($urandom), w});
        end
        for (int a = 32; a < 64; a++) load(a, $urandom);
        model_run(300, ok);
      end
      if (ok) begin
        release_rst();
        finish_prog($sformatf("rnd%0d", p));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_core_bus.md
# cpu_core_bus

Parametrised successor to the single-cycle core. It is a multicycle 16-bit-instruction CPU with configurable datapath width, address width and reset vector. Instruction and data traffic share one external memory port with a req/ack handshake, so wait-stated memory and memory-mapped peripherals (I2C, GPIO) can stall the core. The block adds a resumable halt and a debug register read port.

## Interface
- REG_WIDTH, 16, register/ALU width; legal values are ≥16.
- ADDR_WIDTH, 16, memory address and pc width; must be ≤REG_WIDTH.
- RESET_PC, 0, pc value loaded on reset.

- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory access request; held high until the accepting cycle.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  REG_WIDTH  write data.
- mem_ack  in  1  access completes on a rising edge where mem_req && mem_ack.
- mem_rdata  in  REG_WIDTH  read data; sampled in the accepting cycle.
- resume  in  1  leave HALT, one-cycle pulse.
- halted  out  1  core is in HALT.
- pc  out  ADDR_WIDTH  current pc.
- dbg_sel  in  3  register index.
- dbg_val  out  REG_WIDTH  combinational read of register[dbg_sel].

## Operation
- Instruction format is fixed: op=[15:12], rs=[8:6], rt=[5:3], rd=[2:0], imm6=[11:6], jimm12=[11:0]. A fetch uses mem_rdata[15:0].
- sext(x) is sign extension to REG_WIDTH. All arithmetic is modulo 2^REG_WIDTH. Memory addresses are the low ADDR_WIDTH bits. pc+1 wraps modulo 2^ADDR_WIDTH.
- Opcodes:
  - 0 HALT.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs−rt.
  - 3 AND: rd=rs&rt.
  - 4 OR: rd=rs|rt.
  - 5 ADDI: rd=sext(imm6)+rt.
  - 6 LW: rd=mem[sext(imm6)+rt].
  - 7 SW: mem[sext(imm6)+rt]=rd.
  - 8 BEQ: if rt==rd then pc=pc+1+sext(imm6).
  - 9 J: pc=sext(jimm12).
  - 10–15: NOP (pc+1, no writes).
- There are 8 registers of REG_WIDTH bits, all general-purpose; r0 is writable.
- States: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE → FETCH unconditionally.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On accept, latch the instruction and go to EXEC.
  - EXEC: ALU ops, NOP, BEQ and J update registers/pc, then go to FETCH. LW/SW go to MEM. HALT goes to HALT with pc unchanged.
  - MEM: mem_req=1, mem_addr=sext(imm6)+rt, mem_we=is_sw, mem_wdata=rd value. On accept, LW writes rd from mem_rdata and SW completes; then pc=pc+1 and go to FETCH.
  - HALT: halted=1. On resume: pc=pc+1, go to FETCH. A resume seen in any other state is ignored.
- All operands are read from the register file in EXEC. There is no hazard logic, since only one instruction is in flight.
- mem_req, mem_we, mem_addr and mem_wdata are registered and do not change while mem_req is high and mem_ack is low.

## Timing
- Reset (asynchronous): state=IDLE, pc=RESET_PC, all registers 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
- Reset asserted mid-access drops mem_req immediately. The interrupted access has no architectural effect.
- With zero wait states (mem_ack tied high), the first fetch request appears on the 2nd rising edge after reset release.
- Cycles per instruction with zero wait: ALU/BEQ/J/NOP 2 cycles (FETCH, EXEC); LW/SW 3 cycles. Each wait cycle (mem_req high, mem_ack low) adds 1.
- mem_ack while mem_req is low is ignored.
- A resume pulse in the same cycle the core enters HALT is ignored; only resume sampled while halted=1 counts.
- A register written by an instruction is visible on dbg_val from the next cycle.

## Test plan
- Reset, ack tied 1, program "ADDI r1=5+r0; ADDI r2=−3+r0; ADD r3=r1+r2; HALT" → r3=2, halted=1 after 8 cycles, pc=3.
- SW r1(=0x1234) to address 0x40, then LW r4 from 0x40 with ack delayed 3 cycles each → mem_req held 4 cycles per access with stable addr/wdata, r4=0x1234.
- BEQ with rt==rd and imm6=−2 at pc=5 → next fetch at pc=4. BEQ with rt≠rd → next fetch at pc=6. J with jimm12=0xFFF (ADDR_WIDTH=16) → pc=0xFFFF.
- REG_WIDTH=32: ADDI r1=−1+r0, then ADD r2=r1+r1 → r2=0xFFFFFFFE. mem_addr equals the low ADDR_WIDTH bits of the computed address.
- HALT at pc=2, resume after 10 cycles → fetch at pc=3. A resume pulse during FETCH has no effect.
- Assert rst while MEM is waiting on a SW → mem_req=0 immediately, memory not written, pc=RESET_PC; the first fetch after release goes to RESET_PC.
